// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-to-RAM access sequencer with a four-phase MFC handshake.
// Byte/half/word accesses take one RAM beat. Doubleword accesses take two word
// beats (Addr, then Addr+4). Misaligned requests complete with Err and do not
// touch the RAM.
// Optional feature: define MEM_TIMEOUT_EN to bound each MFC wait to
// TIMEOUT_CYCLES clocks. On expiry the access is abandoned and completes with Err.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        ReadWrite,
  input  logic [1:0]  Size,
  input  logic [7:0]  Addr,
  input  logic [63:0] WData,
  output logic [63:0] RData,
  output logic        Ack,
  output logic        Err,
  output logic        Busy,
  output logic        MemEnable,
  output logic        MemReadWrite,
  output logic [7:0]  MemAddr,
  output logic [31:0] MemDataIn,
  output logic [1:0]  MemWordSel,
  input  logic [31:0] MemDataOut,
  input  logic        MFC
);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_MFC, RELEASE, DONE} state_t;

  state_t      state;
  logic        mfc_meta;
  logic        mfcs;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [7:0]  addr_q;
  logic [63:0] wdata_q;
  logic        beat;
  logic [63:0] rbuf;
  logic        misaligned;
  logic [31:0] first_data;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Two-flop synchronizer for the asynchronous RAM completion flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mfc_meta <= 1'b0;
      mfcs     <= 1'b0;
    end else begin
      mfc_meta <= MFC;
      mfcs     <= mfc_meta;
    end
  end

  // Alignment check and first-beat write data, derived from the latched request
  always_comb begin
    misaligned = 1'b0;
    first_data = '0;
    case (size_q)
      2'b00: first_data = {24'd0, wdata_q[7:0]};
      2'b01: begin
        misaligned = addr_q[0];
        first_data = {16'd0, wdata_q[15:0]};
      end
      2'b10: begin
        misaligned = |addr_q[1:0];
        first_data = wdata_q[31:0];
      end
      default: begin
        misaligned = |addr_q[2:0];
        first_data = wdata_q[63:32];
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  // Timeout counter: the count restarts in each handshake phase and runs only while that phase is still waiting
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      tcnt <= '0;
    else if ((state == WAIT_MFC && !mfcs) || (state == RELEASE && mfcs))
      tcnt <= tcnt + 1'b1;
    else
      tcnt <= '0;
  end

  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Transaction FSM with registered RAM-side and CPU-side outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      rw_q         <= 1'b1;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat         <= 1'b0;
      rbuf         <= '0;
      RData        <= '0;
      Ack          <= 1'b0;
      Err          <= 1'b0;
      Busy         <= 1'b0;
      MemEnable    <= 1'b0;
      MemReadWrite <= 1'b1;
      MemAddr      <= '0;
      MemDataIn    <= '0;
      MemWordSel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            rw_q    <= ReadWrite;
            size_q  <= Size;
            addr_q  <= Addr;
            wdata_q <= WData;
            beat    <= 1'b0;
            Busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (misaligned) begin
            Ack   <= 1'b1;
            Err   <= 1'b1;
            state <= DONE;
          end else begin
            // Address, data and control are set up one cycle before MemEnable rises
            MemAddr      <= addr_q;
            MemReadWrite <= rw_q;
            MemWordSel   <= (size_q == 2'b11) ? 2'b10 : size_q;
            MemDataIn    <= first_data;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // Previous handshake (or a post-reset MFC) must be fully released first
          if (!mfcs) begin
            MemEnable <= 1'b1;
            state     <= WAIT_MFC;
          end
        end
        WAIT_MFC: begin
          if (mfcs) begin
            if (rw_q) begin
              case (size_q)
                2'b00:   rbuf <= {56'd0, MemDataOut[7:0]};
                2'b01:   rbuf <= {48'd0, MemDataOut[15:0]};
                2'b10:   rbuf <= {32'd0, MemDataOut};
                default: begin
                  if (beat) rbuf[31:0]  <= MemDataOut;
                  else      rbuf[63:32] <= MemDataOut;
                end
              endcase
            end
            MemEnable <= 1'b0;
            state     <= RELEASE;
          end else if (timeout_hit) begin
            MemEnable <= 1'b0;
            Ack       <= 1'b1;
            Err       <= 1'b1;
            state     <= DONE;
          end
        end
        RELEASE: begin
          if (!mfcs) begin
            if (size_q == 2'b11 && !beat) begin
              beat      <= 1'b1;
              MemAddr   <= addr_q + 8'd4;
              MemDataIn <= wdata_q[31:0];
              state     <= ISSUE;
            end else begin
              if (rw_q) RData <= rbuf;
              Ack   <= 1'b1;
              Err   <= 1'b0;
              state <= DONE;
            end
          end else if (timeout_hit) begin
            Ack   <= 1'b1;
            Err   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Ack   <= 1'b0;
          Err   <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array RAM with MFC handshake, plus a
// byte-level reference memory that predicts completion status and read data.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req = 1'b0;
  logic        ReadWrite = 1'b1;
  logic [1:0]  Size = '0;
  logic [7:0]  Addr = '0;
  logic [63:0] WData = '0;
  logic [63:0] RData;
  logic        Ack, Err, Busy, MemEnable, MemReadWrite;
  logic [7:0]  MemAddr;
  logic [31:0] MemDataIn;
  logic [1:0]  MemWordSel;
  logic [31:0] MemDataOut = '0;
  logic        MFC = 1'b0;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .ReadWrite(ReadWrite), .Size(Size),
    .Addr(Addr), .WData(WData), .RData(RData), .Ack(Ack), .Err(Err), .Busy(Busy),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemAddr(MemAddr),
    .MemDataIn(MemDataIn), .MemWordSel(MemWordSel), .MemDataOut(MemDataOut), .MFC(MFC)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  sel;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
  } beat_t;

  typedef struct packed {
    logic        err;
    logic        rw;
    logic [63:0] rdata;
  } txn_t;

  logic [7:0]  ram [256];
  logic [7:0]  ref_mem [256];
  beat_t       exp_beats [$];
  txn_t        exp_txn [$];
  logic [63:0] model_rdata = '0;
  int unsigned mfc_delay = 0;
  bit          en_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model: completes an access mfc_delay cycles after seeing MemEnable, then releases MFC
  initial begin : ram_model
    int unsigned cnt;
    bit          held;
    logic [7:0]  la;
    logic [31:0] ld;
    logic        lrw;
    logic [1:0]  lsel;
    logic [31:0] g;
    logic [31:0] m;
    beat_t       e;
    cnt = 0;
    held = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      if (!Reset_n) begin
        MFC = 1'b0; cnt = 0; held = 1'b0;
      end else if (MemEnable) begin
        en_seen = 1'b1;
        if (!held) begin
          held = 1'b1; la = MemAddr; ld = MemDataIn; lrw = MemReadWrite; lsel = MemWordSel;
        end else begin
          check("stable_addr", MemAddr, la);
          check("stable_ctl", {MemReadWrite, MemWordSel}, {lrw, lsel});
          check("stable_data", MemDataIn, ld);
        end
        if (!MFC) begin
          if (cnt >= mfc_delay) begin
            m = (MemWordSel == 2'b00) ? 32'hFF : (MemWordSel == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
            tests++;
            if (exp_beats.size() == 0) begin
              fails++;
              $display("FAIL unexpected_beat: got addr %h sel %b rw %b expected no RAM access",
                       MemAddr, MemWordSel, MemReadWrite);
            end else begin
              e = exp_beats.pop_front();
              check("beat_ctl", {MemReadWrite, MemWordSel, MemAddr}, {e.rw, e.sel, e.addr});
              if (!e.rw) check("beat_wdata", MemDataIn & e.mask, e.data);
            end
            g = $urandom();
            if (MemReadWrite) begin
              case (MemWordSel)
                2'b00:   MemDataOut = {g[31:8], ram[MemAddr]};
                2'b01:   MemDataOut = {g[31:16], ram[MemAddr], ram[8'(MemAddr + 8'd1)]};
                default: MemDataOut = {ram[MemAddr], ram[8'(MemAddr + 8'd1)],
                                       ram[8'(MemAddr + 8'd2)], ram[8'(MemAddr + 8'd3)]};
              endcase
            end else begin
              case (MemWordSel)
                2'b00: ram[MemAddr] = MemDataIn[7:0];
                2'b01: begin
                  ram[MemAddr] = MemDataIn[15:8];
                  ram[8'(MemAddr + 8'd1)] = MemDataIn[7:0];
                end
                default: begin
                  ram[MemAddr] = MemDataIn[31:24];
                  ram[8'(MemAddr + 8'd1)] = MemDataIn[23:16];
                  ram[8'(MemAddr + 8'd2)] = MemDataIn[15:8];
                  ram[8'(MemAddr + 8'd3)] = MemDataIn[7:0];
                end
              endcase
            end
            MFC = 1'b1;
            cnt = 0;
          end else begin
            cnt++;
          end
        end
      end else begin
        held = 1'b0; cnt = 0; MFC = 1'b0;
      end
    end
  end

  // Compare process: completion status per Ack, RData against the model every cycle
  initial begin : monitor
    bit   prev_ack;
    txn_t t;
    prev_ack = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        if (Ack) begin
          check("ack_one_cycle", {63'd0, prev_ack}, 64'd0);
          tests++;
          if (exp_txn.size() == 0) begin
            fails++;
            $display("FAIL unexpected_ack: got Ack=1 expected no completion");
          end else begin
            t = exp_txn.pop_front();
            check("ack_err", {63'd0, Err}, {63'd0, t.err});
            if (t.rw && !t.err) model_rdata = t.rdata;
          end
        end else begin
          check("err_without_ack", {63'd0, Err}, 64'd0);
        end
        check("rdata", RData, model_rdata);
        prev_ack = Ack;
      end else begin
        prev_ack = 1'b0;
      end
    end
  end

  // One CPU transaction: predict from byte-level memory rules, then drive and await Ack
  task automatic do_txn(input logic rw, input logic [1:0] size, input logic [7:0] addr,
                        input logic [63:0] wdata, input int unsigned dly, input bit hold);
    int unsigned n, bn, nb;
    bit          mis, tmo;
    logic [63:0] rd, sh;
    beat_t       b;
    txn_t        t;
    int          c;
    n   = 1 << size;
    mis = (addr % n) != 0;
    tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo = !mis && dly >= 12;
`endif
    rd = '0;
    if (!mis && !tmo) begin
      bn = (n > 4) ? 4 : n;
      nb = n / bn;
      for (int unsigned k = 0; k < nb; k++) begin
        sh     = wdata >> (8 * (n - 4 * k - bn));
        b.rw   = rw;
        b.sel  = (bn == 1) ? 2'b00 : (bn == 2) ? 2'b01 : 2'b10;
        b.addr = 8'(addr + 4 * k);
        b.mask = (bn == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bn)) - 32'd1);
        b.data = sh[31:0] & b.mask;
        exp_beats.push_back(b);
      end
      for (int unsigned i = 0; i < n; i++) begin
        if (rw) rd = {rd[55:0], ref_mem[8'(addr + i)]};
        else    ref_mem[8'(addr + i)] = wdata[(n - 1 - i) * 8 +: 8];
      end
    end
    t.err = mis || tmo; t.rw = rw; t.rdata = rd;
    exp_txn.push_back(t);

    mfc_delay = dly;
    @(negedge Clk);
    en_seen = 1'b0;
    Req = 1'b1; ReadWrite = rw; Size = size; Addr = addr; WData = wdata;
    @(negedge Clk);
    check("busy_after_req", {63'd0, Busy}, 64'd1);
    if (!hold) begin
      Req = 1'b0; ReadWrite = $urandom_range(0, 1); Addr = 8'($urandom()); WData = {$urandom(), $urandom()};
    end
    c = 0;
    while (!Ack && c < 300) begin
      @(negedge Clk);
      c++;
    end
    if (!Ack) begin
      tests++; fails++;
      $display("FAIL ack_timeout: got no Ack expected one within 300 cycles");
    end
    @(negedge Clk);
    Req = 1'b0;
    check("busy_after_done", {63'd0, Busy}, 64'd0);
    check("beats_consumed", 64'(exp_beats.size()), 64'd0);
    if (mis) check("no_ram_on_misalign", {63'd0, en_seen}, 64'd0);
    exp_beats.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin : stimulus
    int c;
    int unsigned sz;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_enable", {63'd0, MemEnable}, 64'd0);
    check("rst_ack_err_busy", {61'd0, Ack, Err, Busy}, 64'd0);
    check("rst_rdata", RData, 64'd0);
    check("rst_memaddr", {56'd0, MemAddr}, 64'd0);
    check("rst_memdatain", {32'd0, MemDataIn}, 64'd0);
    check("rst_ctl", {61'd0, MemReadWrite, MemWordSel}, 64'd4);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Word write then word read
    do_txn(1'b0, 2'b10, 8'h10, 64'h11223344, 0, 1'b0);
    do_txn(1'b1, 2'b10, 8'h10, 64'h0, 1, 1'b0);
    check("word_read_literal", RData, 64'h0000_0000_1122_3344);

    // Doubleword write, byte read from its last byte
    do_txn(1'b0, 2'b11, 8'h20, 64'hA1A2A3A4B1B2B3B4, 1, 1'b1);
    check("dword_beat0_ram", {56'd0, ram[8'h20]}, 64'hA1);
    check("dword_beat1_ram", {56'd0, ram[8'h24]}, 64'hB1);
    do_txn(1'b1, 2'b00, 8'h27, 64'h0, 2, 1'b1);
    check("byte_read_literal", RData, 64'hB4);

    // Misaligned half read
    do_txn(1'b1, 2'b01, 8'h11, 64'h0, 0, 1'b0);

    // Top-of-memory word and doubleword
    do_txn(1'b0, 2'b10, 8'hFC, 64'hDEADBEEF, 0, 1'b0);
    do_txn(1'b1, 2'b10, 8'hFC, 64'h0, 0, 1'b0);
    check("top_word_literal", RData, 64'h0000_0000_DEAD_BEEF);
    do_txn(1'b0, 2'b11, 8'hF8, 64'h0102030405060708, 0, 1'b0);
    do_txn(1'b1, 2'b11, 8'hF8, 64'h0, 1, 1'b0);
    check("top_dword_literal", RData, 64'h0102030405060708);

    // Slow MFC: abandoned when the timeout is built in, otherwise waited out
    do_txn(1'b1, 2'b10, 8'h10, 64'h0, 20, 1'b0);
`ifndef MEM_TIMEOUT_EN
    check("slow_mfc_literal", RData, 64'h0000_0000_1122_3344);
`endif

    // Reset during the first beat of a doubleword write
    mfc_delay = 30;
    @(negedge Clk);
    Req = 1'b1; ReadWrite = 1'b0; Size = 2'b11; Addr = 8'h40; WData = 64'hFFEEDDCCBBAA9988;
    @(negedge Clk);
    Req = 1'b0;
    c = 0;
    while (!MemEnable && c < 50) begin
      @(negedge Clk);
      c++;
    end
    check("mid_reset_enable_seen", {63'd0, MemEnable}, 64'd1);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    model_rdata = '0;
    #1;
    check("mid_reset_enable", {63'd0, MemEnable}, 64'd0);
    check("mid_reset_ack_err_busy", {61'd0, Ack, Err, Busy}, 64'd0);
    check("mid_reset_rdata", RData, 64'd0);
    check("mid_reset_memaddr", {56'd0, MemAddr}, 64'd0);
    check("mid_reset_ctl", {61'd0, MemReadWrite, MemWordSel}, 64'd4);
    check("mid_reset_memdatain", {32'd0, MemDataIn}, 64'd0);
    exp_beats.delete();
    exp_txn.delete();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    mfc_delay = 0;
    repeat (2) @(negedge Clk);
    do_txn(1'b1, 2'b11, 8'h40, 64'h0, 0, 1'b0);

    // Randomized traffic, mostly aligned
    for (int i = 0; i < 80; i++) begin
      sz = $urandom_range(0, 3);
      a  = 8'($urandom());
      if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << sz) - 1);
      do_txn(1'($urandom_range(0, 1)), 2'(sz), a, {$urandom(), $urandom()},
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
